// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined add/subtract unit with valid/ready handshakes.
// The carry chain is split into STAGES chunks of WIDTH/STAGES bits; chunk k
// is summed in stage k using the carry registered by stage k-1. The last
// stage also forms the flags and applies optional signed saturation.
module pipe_addsub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             mode,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // One in-flight operation: operands (b already inverted for sub), the
    // partial sum of the chunks done so far, and the carry into the next chunk.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             mode;
        logic             sat;
    } slot_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             ovf;
        logic             zero;
        logic             neg;
    } res_t;

    // Sum of chunk k of a and b plus carry-in; MSB is the chunk carry-out.
    function automatic logic [CHUNK:0] chunk_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic cin, input int k);
        return {1'b0, a[k*CHUNK +: CHUNK]} + {1'b0, b[k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, cin};
    endfunction

    // Insert a finished chunk into the partial sum (upper bits are still zero).
    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] s,
                                               input logic [CHUNK-1:0] part,
                                               input int k);
        return s | (WIDTH'(part) << (k * CHUNK));
    endfunction

    function automatic slot_t fold(input slot_t x, input int k);
        slot_t          y;
        logic [CHUNK:0] part;
        y    = x;
        part = chunk_add(x.a, x.b, x.c, k);
        y.s  = merge(x.s, part[CHUNK-1:0], k);
        y.c  = part[CHUNK];
        return y;
    endfunction

    // Last chunk plus flags and saturation.
    function automatic res_t finish(input slot_t x);
        res_t             r;
        logic [CHUNK:0]   part;
        logic [WIDTH-1:0] raw;
        logic             sa;
        part     = chunk_add(x.a, x.b, x.c, STAGES-1);
        raw      = merge(x.s, part[CHUNK-1:0], STAGES-1);
        sa       = x.a[WIDTH-1];
        r.ovf    = (sa == x.b[WIDTH-1]) && (raw[WIDTH-1] != sa);
        r.carry  = part[CHUNK] ^ x.mode;
        r.result = (x.sat && r.ovf) ? (sa ? S_MIN : S_MAX) : raw;
        r.zero   = (r.result == '0);
        r.neg    = r.result[WIDTH-1];
        return r;
    endfunction

    logic  stall;
    slot_t head;
    slot_t fin_slot;
    logic  fin_valid;
    res_t  fin_res;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign head     = '{a: opA, b: (mode ? ~opB : opB), s: '0,
                        c: mode, mode: mode, sat: sat};

    if (STAGES == 1) begin : g_single
        assign fin_slot  = head;
        assign fin_valid = in_valid;
    end else begin : g_pipe
        for (genvar k = 0; k < STAGES-1; k++) begin : g_stage
            slot_t src;
            logic  src_valid;
            slot_t slot_q;
            logic  valid_q;

            if (k == 0) begin : g_first
                assign src       = head;
                assign src_valid = in_valid;
            end else begin : g_next
                assign src       = g_stage[k-1].slot_q;
                assign src_valid = g_stage[k-1].valid_q;
            end

            // Stage k: add chunk k and pass the rest along; freeze on stall.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    slot_q  <= '0;
                end else if (!stall) begin
                    valid_q <= src_valid;
                    if (src_valid) begin
                        slot_q <= fold(src, k);
                    end
                end
            end
        end

        assign fin_slot  = g_stage[STAGES-2].slot_q;
        assign fin_valid = g_stage[STAGES-2].valid_q;
    end

    assign fin_res = finish(fin_slot);

    // Final stage: registered result and flags; bubbles leave them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: result and flags are reset too, since they are visible
            // outputs with a defined reset value, not just internal payload.
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
        end else if (!stall) begin
            // NOTE: non-blocking updates so every stage samples pre-edge values.
            out_valid <= fin_valid;
            if (fin_valid) begin
                result <= fin_res.result;
                carry  <= fin_res.carry;
                ovf    <= fin_res.ovf;
                zero   <= fin_res.zero;
                neg    <= fin_res.neg;
            end
        end
    end
endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: three configurations (8/2, 16/4, 8/1) driven from shared
// stimulus. A scoreboard computes expected results from signed/unsigned
// integer arithmetic; directed cases also carry hand-computed literals.
module tb_pipe_addsub;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        mode;
    logic        sat;
    logic        out_ready;
    logic [15:0] opa;
    logic [15:0] opb;

    logic       rdy0, ov0, c0, o0, z0, n0;
    logic [7:0] res0;
    logic        rdy1, ov1, c1, o1, z1, n1;
    logic [15:0] res1;
    logic       rdy2, ov2, c2, o2, z2, n2;
    logic [7:0] res2;

    // {in_ready, out_valid, result[15:0], carry, ovf, zero, neg}
    logic [21:0] obs [3];

    int checks   = 0;
    int failures = 0;

    logic [19:0] sb_mem [3][64];
    int          wr_ptr [3] = '{0, 0, 0};
    int          rd_ptr [3] = '{0, 0, 0};
    logic [19:0] last_out [3] = '{20'h0, 20'h0, 20'h0};

    pipe_addsub #(.WIDTH(8), .STAGES(2)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .opA(opa[7:0]), .opB(opb[7:0]), .mode(mode), .sat(sat),
        .out_valid(ov0), .out_ready(out_ready), .result(res0),
        .carry(c0), .ovf(o0), .zero(z0), .neg(n0)
    );

    pipe_addsub #(.WIDTH(16), .STAGES(4)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .opA(opa), .opB(opb), .mode(mode), .sat(sat),
        .out_valid(ov1), .out_ready(out_ready), .result(res1),
        .carry(c1), .ovf(o1), .zero(z1), .neg(n1)
    );

    pipe_addsub #(.WIDTH(8), .STAGES(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .opA(opa[7:0]), .opB(opb[7:0]), .mode(mode), .sat(sat),
        .out_valid(ov2), .out_ready(out_ready), .result(res2),
        .carry(c2), .ovf(o2), .zero(z2), .neg(n2)
    );

    assign obs[0] = {rdy0, ov0, 8'h00, res0, c0, o0, z0, n0};
    assign obs[1] = {rdy1, ov1, res1, c1, o1, z1, n1};
    assign obs[2] = {rdy2, ov2, 8'h00, res2, c2, o2, z2, n2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dut_w(input int d);
        return (d == 1) ? 16 : 8;
    endfunction

    function automatic int dut_lat(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
    endfunction

    // Expected {result, carry, ovf, zero, neg} from plain integer arithmetic.
    function automatic logic [19:0] model(input int w, input logic [15:0] a_in,
                                          input logic [15:0] b_in,
                                          input logic m, input logic s);
        longint mask, a, b, sa, sb, t, mx, mn, r;
        logic   c, o;
        mask = (64'sd1 <<< w) - 1;
        a    = longint'(a_in) & mask;
        b    = longint'(b_in) & mask;
        sa   = (a >= (64'sd1 <<< (w-1))) ? a - (64'sd1 <<< w) : a;
        sb   = (b >= (64'sd1 <<< (w-1))) ? b - (64'sd1 <<< w) : b;
        if (m) begin
            t = sa - sb;
            c = (a < b);
            r = (a - b) & mask;
        end else begin
            t = sa + sb;
            c = ((a + b) > mask);
            r = (a + b) & mask;
        end
        mx = (64'sd1 <<< (w-1)) - 1;
        mn = -(64'sd1 <<< (w-1));
        o  = (t > mx) || (t < mn);
        if (s && o) r = (t > mx) ? mx : (mn & mask);
        return {r[15:0], c, o, (r == 0), r[w-1]};
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare process: handshake rule, in-order data, stability and hold.
    always @(negedge clk) begin : monitor
        logic [19:0] data;
        logic        ov;
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                wr_ptr[d]   = 0;
                rd_ptr[d]   = 0;
                last_out[d] = 20'h0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                data = obs[d][19:0];
                ov   = obs[d][20];
                check($sformatf("d%0d_in_ready", d), obs[d][21], !(ov && !out_ready));
                if (ov) begin
                    check($sformatf("d%0d_expected_out", d), (wr_ptr[d] != rd_ptr[d]), 1);
                    if (wr_ptr[d] != rd_ptr[d]) begin
                        check($sformatf("d%0d_out_data", d), data, sb_mem[d][rd_ptr[d] % 64]);
                        if (out_ready) begin
                            last_out[d] = data;
                            rd_ptr[d]++;
                        end
                    end
                end else begin
                    check($sformatf("d%0d_hold", d), data, last_out[d]);
                end
                if (in_valid && obs[d][21]) begin
                    sb_mem[d][wr_ptr[d] % 64] = model(dut_w(d), opa, opb, mode, sat);
                    wr_ptr[d]++;
                end
            end
        end
    end

    // One isolated op: per-config latency plus literal expectations.
    task automatic run_directed(input logic [15:0] a, input logic [15:0] b,
                                input logic m, input logic s,
                                input logic [19:0] e8, input logic [19:0] e16);
        bit seen [3] = '{0, 0, 0};
        @(posedge clk); #1;
        opa = a; opb = b; mode = m; sat = s; in_valid = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (!seen[d] && obs[d][20]) begin
                    seen[d] = 1'b1;
                    check($sformatf("d%0d_latency", d), n, dut_lat(d));
                    check($sformatf("d%0d_literal", d), obs[d][19:0], (d == 1) ? e16 : e8);
                end
            end
        end
        for (int d = 0; d < 3; d++) check($sformatf("d%0d_arrived", d), seen[d], 1);
    endtask

    task automatic run_stream();
        int first [3] = '{-1, -1, -1};
        int cnt   [3] = '{0, 0, 0};
        int lastk [3] = '{-1, -1, -1};
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            in_valid = (k < 6);
            opa  = 16'(k * 37 + 5);
            opb  = 16'(k * 11 + 2);
            mode = k[0];
            sat  = 1'b0;
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (obs[d][20]) begin
                    if (first[d] < 0) first[d] = k;
                    cnt[d]++;
                    lastk[d] = k;
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d_stream_first", d), first[d], dut_lat(d));
            check($sformatf("d%0d_stream_count", d), cnt[d], 6);
            check($sformatf("d%0d_stream_run", d), lastk[d] - first[d], 5);
        end
    endtask

    task automatic run_stall();
        logic [19:0] held [3];
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            in_valid  = (k < 20);
            out_ready = !(k >= 10 && k < 15);
            opa  = 16'(k * 4099 + 123);
            opb  = 16'(k * 771 + 9);
            mode = k[0];
            sat  = k[1];
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (k == 10) held[d] = obs[d][19:0];
                if (k == 14) begin
                    check($sformatf("d%0d_stall_valid", d), obs[d][20], 1);
                    check($sformatf("d%0d_stall_ready", d), obs[d][21], 0);
                    check($sformatf("d%0d_stall_stable", d), obs[d][19:0], held[d]);
                end
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic run_random(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            opa  = 16'($urandom);
            opb  = 16'($urandom);
            mode = 1'($urandom);
            sat  = 1'($urandom);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    task automatic drain();
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            check($sformatf("d%0d_pending", d), wr_ptr[d] - rd_ptr[d], 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin : driver
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opa = '0; opb = '0; mode = 1'b0; sat = 1'b0;
        #3;
        for (int d = 0; d < 3; d++)
            check($sformatf("d%0d_reset_state", d), obs[d], 22'h200000);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_directed(16'h000F, 16'h0003, 1, 0, {16'h000C, 4'b0000}, {16'h000C, 4'b0000});
        run_directed(16'h0003, 16'h000F, 1, 0, {16'h00F4, 4'b1001}, {16'hFFF4, 4'b1001});
        run_directed(16'h00FF, 16'h0001, 0, 0, {16'h0000, 4'b1010}, {16'h0100, 4'b0000});
        run_directed(16'h007F, 16'h0001, 0, 0, {16'h0080, 4'b0101}, {16'h0080, 4'b0000});
        run_directed(16'h007F, 16'h0001, 0, 1, {16'h007F, 4'b0100}, {16'h0080, 4'b0000});
        run_directed(16'h0080, 16'h0001, 1, 1, {16'h0080, 4'b0101}, {16'h007F, 4'b0000});
        run_directed(16'h7FFF, 16'h0001, 0, 1, {16'h0000, 4'b1010}, {16'h7FFF, 4'b0100});
        run_directed(16'h8000, 16'h0001, 1, 0, {16'h00FF, 4'b1001}, {16'h7FFF, 4'b0100});
        run_directed(16'h1234, 16'h1234, 1, 0, {16'h0000, 4'b0010}, {16'h0000, 4'b0010});
        run_directed(16'h0FFF, 16'h0001, 0, 0, {16'h0000, 4'b1010}, {16'h1000, 4'b0000});
        run_directed(16'h8000, 16'hFFFF, 0, 1, {16'h00FF, 4'b0001}, {16'h8000, 4'b1101});

        run_stream();
        drain();
        run_stall();
        drain();
        run_random(300);
        drain();

        // Reset with operations in flight, then a fresh op must come out alone.
        @(posedge clk); #1;
        in_valid = 1'b1; opa = 16'h0021; opb = 16'h0005; mode = 1'b0; sat = 1'b0;
        @(posedge clk); #1;
        opa = 16'h0044; opb = 16'h0011; mode = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++)
            check($sformatf("d%0d_async_reset", d), obs[d], 22'h200000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_directed(16'h000F, 16'h0003, 1, 0, {16'h000C, 4'b0000}, {16'h000C, 4'b0000});
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
